// File: rtl/key_sched_128.sv
// key_sched_128: AES-128 key schedule sequencer driving an external expansion stage
// and storing the eleven round keys for single-cycle registered reads.
module key_sched_128 #(
    parameter int EXP_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic         key_valid,
    output logic [127:0] exp_in,
    output logic [7:0]   exp_rcon,
    input  logic [127:0] exp_out,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data
);
    localparam int CW = EXP_LAT < 1 ? 1 : $clog2(EXP_LAT + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t         state;
    logic [CW-1:0]  wcnt;
    logic [3:0]     round;
    // entries 11..15 are never written, so out-of-range reads return zero
    logic [127:0]   rk [0:15];
    logic           capture;
    logic [7:0]     rcon_next;
    assign capture   = state == RUN && wcnt == CW'(EXP_LAT);
    assign rcon_next = {exp_rcon[6:0], 1'b0} ^ (exp_rcon[7] ? 8'h1b : 8'h00);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_valid <= 1'b0;
            exp_in    <= '0;
            exp_rcon  <= '0;
            rk_data   <= '0;
            round     <= '0;
            wcnt      <= '0;
            for (int i = 0; i < 16; i++) rk[i] <= '0;
        end else begin
            rk_data <= rk[rk_addr];
            done    <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= RUN;
                    ready     <= 1'b0;
                    busy      <= 1'b1;
                    key_valid <= 1'b0;
                    rk[0]     <= key_in;
                    exp_in    <= key_in;
                    exp_rcon  <= 8'h01;
                    round     <= 4'd1;
                    wcnt      <= '0;
                end
                RUN: if (capture) begin
                    rk[round] <= exp_out;
                    exp_in    <= exp_out;
                    exp_rcon  <= rcon_next;
                    round     <= round + 4'd1;
                    wcnt      <= '0;
                    if (round == 4'd10) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end else begin
                    wcnt <= wcnt + CW'(1);
                end
                DONE: begin
                    key_valid <= 1'b1;
                    ready     <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_sched_128.sv
// tb_key_sched_128: scoreboard bench with a 2-cycle AES key expansion stage model;
// stimulus queues expected read data, done timing and rcon changes, a monitor checks them.
module tb_key_sched_128;
    logic         clk = 0;
    logic         rst = 1;
    logic         start = 0;
    logic [127:0] key_in = '0;
    logic         ready, busy, done, key_valid;
    logic [127:0] exp_in, exp_out, rk_data;
    logic [7:0]   exp_rcon;
    logic [3:0]   rk_addr = '0;
    logic [127:0] p1 = '0;
    logic         rd_issue = 0, rd_vld = 0;
    int           cyc = 0, c0 = 0, checks = 0, errors = 0;
    logic [127:0] rd_q [$];
    int           done_q [$];
    int           rc_cyc [$];
    logic [7:0]   rc_val [$];
    logic [7:0]   prev_rcon = '0;
    logic [127:0] mk [0:10];

    key_sched_128 #(.EXP_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .ready(ready), .busy(busy),
        .done(done), .key_valid(key_valid), .exp_in(exp_in), .exp_rcon(exp_rcon),
        .exp_out(exp_out), .rk_addr(rk_addr), .rk_data(rk_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        for (int y = 1; y < 256; y++)
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]};
        return s ^ 8'h63;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] w, input logic [7:0] rc);
        logic [31:0] w3 = w[31:0];
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        n0 = w[127:96] ^ t;
        n1 = w[95:64] ^ n0;
        n2 = w[63:32] ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // two-register expansion stage: exp_out valid two edges after exp_in changes
    always @(posedge clk) begin
        p1      <= expand(exp_in, exp_rcon);
        exp_out <= p1;
        rd_vld  <= rd_issue;
        cyc     <= cyc + 1;
    end

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endtask

    task automatic fail(input string n);
        checks++;
        errors++;
        $display("FAIL %s", n);
    endtask

    always @(posedge clk) begin
        #1;
        if (rd_vld) begin
            if (rd_q.size() == 0) fail("rd_unexpected");
            else chk("rk_data", rk_data, rd_q.pop_front());
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) fail("done_unexpected");
            else chk("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
        end
        if (exp_rcon !== prev_rcon && exp_rcon !== 8'h00) begin
            if (rc_val.size() == 0) fail("rcon_unexpected");
            else begin
                chk("rcon_val", 128'(exp_rcon), 128'(rc_val.pop_front()));
                chk("rcon_cycle", 128'(cyc), 128'(rc_cyc.pop_front()));
            end
        end
        prev_rcon = exp_rcon;
    end

    task automatic launch(input logic [127:0] k);
        logic [7:0] rc = 8'h01;
        start  = 1;
        key_in = k;
        @(posedge clk);
        c0 = cyc;
        done_q.push_back(c0 + 31);
        mk[0] = k;
        rc_val.push_back(rc);
        rc_cyc.push_back(c0 + 1);
        for (int r = 1; r <= 10; r++) begin
            mk[r] = expand(mk[r-1], rc);
            rc = xt(rc);
            rc_val.push_back(rc);
            rc_cyc.push_back(c0 + 3 * r + 1);
        end
        @(negedge clk);
        start = 0;
    endtask

    task automatic at_edge(input int e);
        while (cyc < c0 + e) @(negedge clk);
    endtask

    task automatic rd(input logic [3:0] a, input logic [127:0] e);
        rk_addr  = a;
        rd_issue = 1;
        rd_q.push_back(e);
        @(negedge clk);
        rd_issue = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && done_q.size() != 0; i++) @(negedge clk);
        if (done_q.size() != 0) begin
            fail("done_timeout");
            done_q.delete();
        end
        while (rd_q.size() != 0) @(negedge clk);
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("rst_ready", 128'(ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_kv", 128'(key_valid), 128'd0);
        chk("rst_exp_in", exp_in, '0);
        chk("rst_rdata", rk_data, '0);
        @(negedge clk);
        rst = 0;
        // run 1: FIPS-197 key with ignored start pulses at edges 5 and 30
        launch(128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("run_busy", 128'(busy), 128'd1);
        chk("run_ready", 128'(ready), 128'd0);
        rd(4'd5, '0);
        at_edge(5);
        start = 1; key_in = '1;
        @(negedge clk);
        start = 0;
        at_edge(30);
        start = 1; key_in = '1;
        @(negedge clk);
        start = 0;
        wait_done();
        @(negedge clk);
        chk("kv_after_done", 128'(key_valid), 128'd1);
        chk("ready_after_done", 128'(ready), 128'd1);
        rd(4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        for (int a = 0; a < 16; a++) rd(4'(a), a <= 10 ? mk[a] : '0);
        while (rd_q.size() != 0) @(negedge clk);
        // run 2 started on the first IDLE cycle after done, then run 3 back to back
        launch(128'h000102030405060708090a0b0c0d0e0f);
        wait_done();
        @(negedge clk);
        chk("kv_before_b2b", 128'(key_valid), 128'd1);
        launch('0);
        chk("kv_cleared", 128'(key_valid), 128'd0);
        wait_done();
        @(negedge clk);
        rd(4'd0, '0);
        rd(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        rd(4'd7, mk[7]);
        while (rd_q.size() != 0) @(negedge clk);
        // run 4: asynchronous reset during round 5
        launch(128'h2b7e151628aed2a6abf7158809cf4f3c);
        at_edge(14);
        #2 rst = 1;
        #1;
        done_q.delete();
        rc_val.delete();
        rc_cyc.delete();
        chk("arst_ready", 128'(ready), 128'd1);
        chk("arst_busy", 128'(busy), 128'd0);
        chk("arst_rcon", 128'(exp_rcon), 128'd0);
        chk("arst_exp_in", exp_in, '0);
        chk("arst_rdata", rk_data, '0);
        repeat (20) @(negedge clk);
        rst = 0;
        launch(128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd(4'd3, '0);
        wait_done();
        @(negedge clk);
        rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd(4'd12, '0);
        while (rd_q.size() != 0) @(negedge clk);
        repeat (3) @(negedge clk);
        if (rc_val.size() != 0) fail("rcon_missing");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/key_sched_128.md
KEY_SCHED_128 -- requirements
Module: key_sched_128

Interface
REQ-001 Parameter EXP_LAT, default 2: cycles from exp_in/exp_rcon change to valid exp_out on the attached expansion stage.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  one-cycle request to expand key_in; honoured only while ready=1.
REQ-005 key_in  input  128  cipher key, sampled on the accepted start edge.
REQ-006 ready  output  1  high only in IDLE.
REQ-007 busy  output  1  high in RUN.
REQ-008 done  output  1  one-cycle pulse once all round keys are stored.
REQ-009 key_valid  output  1  high from done until the next accepted start or reset.
REQ-010 exp_in  output  128  registered key word driven to the expansion stage input.
REQ-011 exp_rcon  output  8  registered round constant driven to the expansion stage.
REQ-012 exp_out  input  128  expanded key returned from the stage (its EXP_LAT-delayed output).
REQ-013 rk_addr  input  4  round-key read index, 0..10.
REQ-014 rk_data  output  128  registered read data, rk[rk_addr], 1-cycle latency.

Function
REQ-015 FSM states IDLE, RUN, DONE.
- IDLE->RUN on start.
- RUN->DONE on the 10th capture.
- DONE->IDLE unconditionally after one cycle.
REQ-016 Accepted start edge:
- rk[0]<=key_in, exp_in<=key_in, exp_rcon<=8'h01.
- round<=1, wcnt<=0, key_valid<=0.
REQ-017 In RUN, wcnt increments each cycle; a capture occurs on the edge where wcnt==EXP_LAT.
REQ-018 On capture:
- rk[round]<=exp_out and exp_in<=exp_out.
- exp_rcon<=xtime(exp_rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
- round<=round+1, wcnt<=0.
REQ-019 exp_in and exp_rcon stay constant between captures; each round takes EXP_LAT+1 cycles.
REQ-020 exp_rcon sequence over rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
REQ-021 With EXP_LAT=2, done is high exactly 31 cycles after the accepted start edge (30 RUN cycles, then DONE).
REQ-022 In DONE: done=1 and key_valid<=1; on leaving DONE, exp_in and exp_rcon hold their last values.
REQ-023 start while ready=0 (RUN or DONE) is ignored, with no effect on any state.
REQ-024 start on the first IDLE cycle after DONE is accepted normally and clears key_valid.
REQ-025 rk_data<=rk[rk_addr] every cycle regardless of state; rk_addr 11..15 returns 128'h0.
REQ-026 Read and write of the same index on the same edge returns the pre-write contents (read-before-write).
REQ-027 rk entries not yet written in the current run keep their previous contents; consumers qualify reads with key_valid.

Reset
REQ-028 rst=1 forces immediately, independent of clk:
- FSM IDLE.
- ready=1, busy=0, done=0, key_valid=0.
- exp_in=0, exp_rcon=0, rk_data=0.
- round=0, wcnt=0, all rk[0..10]=0.
REQ-029 Reset during RUN or DONE abandons the expansion; no done pulse follows.
REQ-030 The first start is accepted on the first posedge after rst deasserts.

Verification
REQ-031 All scenarios use the real expansion stage (EXP_LAT=2) or a 2-cycle model of it.
REQ-032 FIPS-197 key:
- start, key_in=2b7e151628aed2a6abf7158809cf4f3c -> done at cycle 31.
- rk[1]=a0fafe1788542cb123a339392a6c7605.
- rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-033 Monitor exp_rcon at each capture -> 01,02,04,08,10,20,40,80,1b,36 in order; rcon changes only on capture edges.
REQ-034 start pulses at cycles 5 and 30 of a run -> both ignored; rk contents and done timing unchanged.
REQ-035 rst asserted mid-cycle at round 5 -> all outputs zero before the next posedge, no done pulse; a fresh start completes normally.
REQ-036 Back-to-back runs (key A, start on the first IDLE cycle, then key_in=0) -> key_valid drops on the start edge; rk[10] for key 0 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-037 rk_addr sweep 0..15 after done -> 1-cycle-latency data matches the model; addresses 11..15 return 0.
